// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: operand width, ALU control codes,
// legality check and arbiter FSM state encoding.
package alu_pkg;

   localparam int ALU_W = 64;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_NOR   = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
      case (ctrl)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR: return 1'b1;
         default:                                               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping around. The pointer register is owned by the caller.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   always_comb begin
      int  cand;
      logic found;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(ptr_i) + k) % NUM_REQ;
         if (!found && req_i[IDX_W'(cand)]) begin
            found                  = 1'b1;
            grant_o[IDX_W'(cand)]  = 1'b1;
            idx_o                  = IDX_W'(cand);
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for one shared combinational ALU: accepts one op at a
// time, drives the ALU from registered operands and returns a tagged response.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = ALU_W,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_src1,
   input  logic [NUM_REQ*DATA_W-1:0] req_src2,
   input  logic [NUM_REQ*4-1:0]      req_ctrl,
   output logic [DATA_W-1:0]         alu_src1,
   output logic [DATA_W-1:0]         alu_src2,
   output logic [3:0]                alu_ctrl,
   input  logic [DATA_W-1:0]         alu_result,
   input  logic                      alu_zero,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      rsp_zero,
   output logic                      rsp_err
);

   arb_state_e          state_q;
   logic [ID_W-1:0]     ptr_q;
   logic [DATA_W-1:0]   op_src1_q;
   logic [DATA_W-1:0]   op_src2_q;
   logic [3:0]          op_ctrl_q;
   logic [ID_W-1:0]     op_id_q;
   logic                rsp_valid_q;
   logic [ID_W-1:0]     rsp_id_q;
   logic [DATA_W-1:0]   rsp_result_q;
   logic                rsp_zero_q;
   logic                rsp_err_q;

   logic [DATA_W-1:0]   src1_arr [NUM_REQ];
   logic [DATA_W-1:0]   src2_arr [NUM_REQ];
   logic [3:0]          ctrl_arr [NUM_REQ];

   logic [NUM_REQ-1:0]  pick_grant;
   logic [ID_W-1:0]     pick_idx;
   logic                pick_any;
   logic                arb_en;
   logic                accept;
   logic                op_legal;
   logic [ID_W-1:0]     ptr_d;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign src1_arr[gi] = req_src1[gi*DATA_W +: DATA_W];
      assign src2_arr[gi] = req_src2[gi*DATA_W +: DATA_W];
      assign ctrl_arr[gi] = req_ctrl[gi*4 +: 4];
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (ID_W)
   ) u_picker (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .valid_o (pick_any)
   );

   // Arbitration is open when idle, or when the pending response retires this cycle.
   assign arb_en    = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
   assign req_ready = (rst_n && arb_en) ? pick_grant : '0;
   assign accept    = arb_en && pick_any;
   assign ptr_d     = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
   assign op_legal  = alu_ctrl_legal(op_ctrl_q);

   assign alu_src1   = op_src1_q;
   assign alu_src2   = op_src2_q;
   assign alu_ctrl   = op_ctrl_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         op_src1_q    <= '0;
         op_src2_q    <= '0;
         op_ctrl_q    <= '0;
         op_id_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         if (accept) begin
            op_src1_q <= src1_arr[pick_idx];
            op_src2_q <= src2_arr[pick_idx];
            op_ctrl_q <= ctrl_arr[pick_idx];
            op_id_q   <= pick_idx;
            ptr_q     <= ptr_d;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept) state_q <= ST_EXEC;
            end
            ST_EXEC: begin
               // An unrecognised code leaves the ALU output meaningless, so report a clean error.
               rsp_valid_q  <= 1'b1;
               rsp_id_q     <= op_id_q;
               rsp_result_q <= op_legal ? alu_result : '0;
               rsp_zero_q   <= op_legal ? alu_zero : 1'b1;
               rsp_err_q    <= ~op_legal;
               state_q      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= accept ? ST_EXEC : ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
